wb_rr_arbiter: RTL and testbench
================================

// Module: wb_rr_arbiter
// PURPOSE
//  NM-way Wishbone (pipelined) bus arbiter with a per-transaction timeout watchdog.
//  Shares one downstream WB slave port (the I2C core register port) between several
//  upstream WB masters: the AXI-lite bridge, a local sequencer and a debug port.
//  Grant is held for the whole cyc burst. A stalled or silent slave is aborted with err.
// PARAMETERS
//  NM       4   number of masters, 2..8
//  AW       28  WB address width
//  DW       8   WB data width, multiple of 8
//  TIMEOUT  10  cycles of o_cyc without ack/err before abort, 2..255
// PORTS
//  i_clk      in   1      system clock
//  i_reset    in   1      synchronous, active-high reset
//  i_m_cyc    in   NM     per-master cyc
//  i_m_stb    in   NM     per-master stb
//  i_m_we     in   NM     per-master we
//  i_m_adr    in   NM*AW  per-master addr, master k at [k*AW +: AW]
//  i_m_dat    in   NM*DW  per-master write data
//  i_m_sel    in   NM*DW/8  per-master byte select
//  o_m_stall  out  NM     per-master stall
//  o_m_ack    out  NM     per-master ack
//  o_m_err    out  NM     per-master err
//  o_m_data   out  DW     read data, broadcast to all masters = i_data
//  o_cyc, o_stb, o_we  out  1  downstream control
//  o_adr      out  AW     downstream address
//  o_dat      out  DW     downstream write data
//  o_sel      out  DW/8   downstream byte select
//  i_stall, i_ack, i_err  in  1  downstream response
//  i_data     in   DW     downstream read data
//  o_grant    out  NM     one-hot current owner, 0 when idle
//  o_timeout  out  1      one-cycle pulse on watchdog abort
// BEHAVIOUR
//  - State regs: owner (idx), granted (bit), last (idx), tcnt (8b), abort (bit).
//  - Reset (sync): granted=0, abort=0, tcnt=0, last=NM-1 so master 0 has first priority.
//    Reset values of outputs:
//    - all o_m_ack, o_m_err, o_cyc, o_stb, o_we, o_adr, o_dat, o_sel, o_grant, o_timeout = 0.
//    - o_m_stall = all 1s.
//  - Arbitration happens at the clock edge when !granted, or when the owner's i_m_cyc=0:
//    - Round-robin search from last+1 (mod NM) picks the first k with i_m_cyc[k]=1.
//    - On a hit: owner<=k, last<=k, granted<=1. On no hit: granted<=0.
//    - Latency: cyc asserted in cycle N gives grant and o_cyc in N+1.
//    - Owner handover costs exactly one cycle with o_cyc=0.
//  - o_cyc = granted & i_m_cyc[owner] & !abort. o_stb = o_cyc & i_m_stb[owner].
//  - o_we/o_adr/o_dat/o_sel come from the owner when o_cyc=1; otherwise they are zero.
//  - Per-master responses:
//    - o_m_stall[k] = (k==owner & o_cyc) ? i_stall : 1.
//    - o_m_ack[k] = (k==owner & o_cyc) & i_ack.
//    - o_m_err[k] = (k==owner & o_cyc) & i_err, OR'd with the abort err below.
//  - Watchdog tcnt:
//    - Cleared when o_cyc=0 or when i_ack|i_err.
//    - Otherwise increments, saturating at TIMEOUT.
//    - When tcnt==TIMEOUT-1 and the cycle has no ack/err: next cycle abort=1.
//  - Abort cycle (abort=1):
//    - o_cyc=0, o_timeout=1, o_m_err[owner]=1.
//    - granted<=0, abort<=0, tcnt<=0.
//    - That master rejoins arbitration only after dropping cyc and re-asserting it.
//    - Round-robin still applies, so it goes to the back of the queue.
//  - Boundaries:
//    - ack and timeout in the same cycle: ack wins, no abort.
//    - Owner drops cyc mid-burst: grant released at that edge. Outstanding acks are
//      discarded and not routed.
//    - Masters requesting while another owns the bus: stall held at 1, no timeout counted.
//    - All masters idle: o_grant=0.
//    - Reset mid-transfer: o_cyc falls at the next edge; no ack or err is issued.
//  - Widths: index regs are $clog2(NM) bits. last wraps NM-1 to 0.
// CONFIGURATION
//  WB_ARB_FIXED_PRIO_EN
//  - Defined: fixed priority. The lowest index with cyc wins; `last` is ignored.
//  - Undefined (default): round-robin as above.
//  - Watchdog and abort are identical in both modes.
// TESTING
//  - Reset, then m0 writes adr=0x04 dat=0xA5 -> o_grant=0001 next cycle;
//    o_stb/o_we=1, o_adr=0x04, o_dat=0xA5; o_m_ack[0] with i_ack.
//  - m0..m3 all hold cyc for 3 single-beat bursts each -> grants 0,1,2,3,0,1,...,
//    one idle cycle between owners (fixed-prio build: m0 until it drops cyc).
//  - m1 owns the bus, slave never acks, TIMEOUT=10 -> after 10 cycles of o_cyc:
//    o_timeout=1, o_m_err[1]=1, o_cyc=0, then m2 granted.
//  - i_ack on the 10th cycle (TIMEOUT=10) -> no abort, tcnt cleared, o_m_ack[owner]=1.
//  - m2 stalled by i_stall=1 for 4 cycles, m0 requesting -> o_m_stall[0]=1 throughout,
//    o_m_stall[2] mirrors i_stall.
//  - i_reset asserted while m3 waits for ack -> o_cyc=0 next cycle,
//    o_m_ack=o_m_err=0, then m0 has first priority.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Pipelined Wishbone N-master arbiter with a per-transaction timeout watchdog.
// Define WB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); round-robin otherwise.
module wb_rr_arbiter #(
  parameter int NM      = 4,
  parameter int AW      = 28,
  parameter int DW      = 8,
  parameter int TIMEOUT = 10
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NM-1:0]        i_m_cyc,
  input  logic [NM-1:0]        i_m_stb,
  input  logic [NM-1:0]        i_m_we,
  input  logic [NM*AW-1:0]     i_m_adr,
  input  logic [NM*DW-1:0]     i_m_dat,
  input  logic [NM*DW/8-1:0]   i_m_sel,
  output logic [NM-1:0]        o_m_stall,
  output logic [NM-1:0]        o_m_ack,
  output logic [NM-1:0]        o_m_err,
  output logic [DW-1:0]        o_m_data,
  output logic                 o_cyc,
  output logic                 o_stb,
  output logic                 o_we,
  output logic [AW-1:0]        o_adr,
  output logic [DW-1:0]        o_dat,
  output logic [DW/8-1:0]      o_sel,
  input  logic                 i_stall,
  input  logic                 i_ack,
  input  logic                 i_err,
  input  logic [DW-1:0]        i_data,
  output logic [NM-1:0]        o_grant,
  output logic                 o_timeout
);

  localparam int IW = $clog2(NM);
  localparam int SW = DW / 8;

  logic [IW-1:0] owner, last, pick, cand;
  logic          granted, abort, hit, own_cyc;
  logic [7:0]    tcnt;
  logic [NM-1:0] lockout, req, own_mask;

  // A master aborted by the watchdog stays masked until it drops cyc once.
  assign req = i_m_cyc & ~lockout;

  always_comb begin
    hit  = 1'b0;
    pick = '0;
    cand = '0;
    for (int unsigned i = 0; i < NM; i++) begin
`ifdef WB_ARB_FIXED_PRIO_EN
      cand = IW'(i);
`else
      cand = IW'((32'(last) + 1 + i) % NM);
`endif
      if (!hit && req[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
  end

  always_comb begin
    own_mask = '0;
    for (int unsigned k = 0; k < NM; k++) begin
      if (IW'(k) == owner) own_mask[k] = 1'b1;
    end
  end

  assign own_cyc   = i_m_cyc[owner];
  assign o_cyc     = granted & own_cyc & ~abort;
  assign o_stb     = o_cyc & i_m_stb[owner];
  assign o_we      = o_cyc & i_m_we[owner];
  assign o_adr     = o_cyc ? i_m_adr[int'(owner)*AW +: AW] : '0;
  assign o_dat     = o_cyc ? i_m_dat[int'(owner)*DW +: DW] : '0;
  assign o_sel     = o_cyc ? i_m_sel[int'(owner)*SW +: SW] : '0;
  assign o_m_data  = i_data;
  assign o_grant   = granted ? own_mask : '0;
  assign o_timeout = abort;

  always_comb begin
    o_m_stall = '1;
    o_m_ack   = '0;
    o_m_err   = '0;
    if (o_cyc) begin
      o_m_stall = ~own_mask | (own_mask & {NM{i_stall}});
      o_m_ack   = own_mask & {NM{i_ack}};
      o_m_err   = own_mask & {NM{i_err}};
    end
    if (abort) o_m_err = o_m_err | own_mask;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      granted <= 1'b0;
      abort   <= 1'b0;
      tcnt    <= '0;
      last    <= IW'(NM - 1);
      owner   <= '0;
      lockout <= '0;
    end else begin
      lockout <= (lockout | (abort ? own_mask : '0)) & i_m_cyc;
      if (abort) begin
        granted <= 1'b0;
        abort   <= 1'b0;
        tcnt    <= '0;
      end else begin
        if (!granted || !own_cyc) begin
          granted <= hit;
          if (hit) begin
            owner <= pick;
            last  <= pick;
          end
        end
        if (!o_cyc || i_ack || i_err)
          tcnt <= '0;
        else if (tcnt < 8'(TIMEOUT))
          tcnt <= tcnt + 8'd1;
        // A response in the last allowed cycle wins over the abort.
        abort <= o_cyc & ~(i_ack | i_err) & (tcnt == 8'(TIMEOUT - 1));
      end
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter: per-scenario tasks plus a response monitor.
module tb_wb_rr_arbiter;

  localparam int NM = 4;
  localparam int AW = 28;
  localparam int DW = 8;
  localparam int TO = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_cyc, m_stb, m_we;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_dat;
  logic [NM*DW/8-1:0] m_sel;
  logic [NM-1:0]     m_stall, m_ack, m_err;
  logic [DW-1:0]     m_data;
  logic              cyc, stb, we;
  logic [AW-1:0]     adr;
  logic [DW-1:0]     dat;
  logic [DW/8-1:0]   sel;
  logic              s_stall, s_ack, s_err;
  logic [DW-1:0]     s_data;
  logic [NM-1:0]     grant;
  logic              timeout;

  typedef struct packed {
    logic [NM-1:0] ack;
    logic [NM-1:0] err;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_r;
  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we), .i_m_adr(m_adr),
    .i_m_dat(m_dat), .i_m_sel(m_sel),
    .o_m_stall(m_stall), .o_m_ack(m_ack), .o_m_err(m_err), .o_m_data(m_data),
    .o_cyc(cyc), .o_stb(stb), .o_we(we), .o_adr(adr), .o_dat(dat), .o_sel(sel),
    .i_stall(s_stall), .i_ack(s_ack), .i_err(s_err), .i_data(s_data),
    .o_grant(grant), .o_timeout(timeout)
  );

  // Every ack/err the DUT routes must match the next expected response.
  always @(negedge clk) begin
    if (|m_ack || |m_err) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL resp_unexpected got ack=%b err=%b exp none", m_ack, m_err);
      end else begin
        mon_r = exp_q.pop_front();
        if ({m_ack, m_err} !== {mon_r.ack, mon_r.err})
          $display("FAIL resp_match got ack=%b err=%b exp ack=%b err=%b",
                   m_ack, m_err, mon_r.ack, mon_r.err);
        else pass_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int k, input logic c, input logic s, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_cyc[k] = c;
    m_stb[k] = s;
    m_we[k]  = w;
    m_adr[k*AW +: AW] = a;
    m_dat[k*DW +: DW] = d;
    m_sel[k*(DW/8) +: DW/8] = {(DW/8){c}};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
    s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_data = '0;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    s_data = 8'h3C;
    #1;
    total_cnt++;
    if (grant !== 4'b0000) $display("FAIL reset_grant got=%b exp=0000", grant); else pass_cnt++;
    total_cnt++;
    if ({cyc, stb, we} !== 3'b000) $display("FAIL reset_ctl got=%b exp=000", {cyc, stb, we}); else pass_cnt++;
    total_cnt++;
    if ({adr, dat, sel} !== '0) $display("FAIL reset_bus got=%h exp=0", {adr, dat, sel}); else pass_cnt++;
    total_cnt++;
    if (m_stall !== 4'b1111) $display("FAIL reset_stall got=%b exp=1111", m_stall); else pass_cnt++;
    total_cnt++;
    if ({m_ack, m_err, timeout} !== 9'b0) $display("FAIL reset_resp got=%b exp=0", {m_ack, m_err, timeout}); else pass_cnt++;
    total_cnt++;
    if (m_data !== 8'h3C) $display("FAIL data_bcast got=%h exp=3c", m_data); else pass_cnt++;
  endtask

  task automatic test_basic_write();
    drive_m(0, 1'b1, 1'b1, 1'b1, 28'h4, 8'hA5);
    #1;
    total_cnt++;
    if ({cyc, grant} !== 5'b0_0000) $display("FAIL basic_latency got=%b exp=00000", {cyc, grant}); else pass_cnt++;
    nxt();
    total_cnt++;
    if (grant !== 4'b0001) $display("FAIL basic_grant got=%b exp=0001", grant); else pass_cnt++;
    total_cnt++;
    if ({cyc, stb, we} !== 3'b111) $display("FAIL basic_ctl got=%b exp=111", {cyc, stb, we}); else pass_cnt++;
    total_cnt++;
    if ({adr, dat, sel} !== {28'h4, 8'hA5, 1'b1}) $display("FAIL basic_bus got=%h exp=%h", {adr, dat, sel}, {28'h4, 8'hA5, 1'b1}); else pass_cnt++;
    total_cnt++;
    if (m_stall !== 4'b1110) $display("FAIL basic_stall got=%b exp=1110", m_stall); else pass_cnt++;
    s_ack = 1'b1;
    exp_q.push_back({4'b0001, 4'b0000});
    #1;
    total_cnt++;
    if (m_ack !== 4'b0001) $display("FAIL basic_ack got=%b exp=0001", m_ack); else pass_cnt++;
    nxt();
    s_ack = 1'b0;
    drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    total_cnt++;
    if (cyc !== 1'b0) $display("FAIL basic_drop got=%b exp=0", cyc); else pass_cnt++;
    nxt();
    total_cnt++;
    if (grant !== 4'b0000) $display("FAIL idle_grant got=%b exp=0000", grant); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int exp_k;
    logic [NM-1:0] eg;
    do_reset();
    for (int k = 0; k < NM; k++) drive_m(k, 1'b1, 1'b1, 1'b0, 28'(16*k + 1), 8'(k));
    nxt();
    for (int n = 0; n < 12; n++) begin
`ifdef WB_ARB_FIXED_PRIO_EN
      exp_k = n % 2;
`else
      exp_k = n % NM;
`endif
      eg = 4'(1 << exp_k);
      #1;
      total_cnt++;
      if ({cyc, grant, adr} !== {1'b1, eg, 28'(16*exp_k + 1)})
        $display("FAIL rr_owner n=%0d got cyc=%b grant=%b adr=%h exp cyc=1 grant=%b adr=%h",
                 n, cyc, grant, adr, eg, 28'(16*exp_k + 1));
      else pass_cnt++;
      s_ack = 1'b1;
      s_data = 8'(n);
      exp_q.push_back({eg, 4'b0000});
      nxt();
      s_ack = 1'b0;
      drive_m(exp_k, 1'b0, 1'b0, 1'b0, 28'(16*exp_k + 1), 8'(exp_k));
      #1;
      total_cnt++;
      if (cyc !== 1'b0) $display("FAIL rr_gap n=%0d got=%b exp=0", n, cyc); else pass_cnt++;
      nxt();
      drive_m(exp_k, 1'b1, 1'b1, 1'b0, 28'(16*exp_k + 1), 8'(exp_k));
    end
    m_cyc = '0; m_stb = '0;
    nxt();
    nxt();
  endtask

  task automatic test_timeout();
    do_reset();
    drive_m(1, 1'b1, 1'b1, 1'b1, 28'h10, 8'h11);
    drive_m(2, 1'b1, 1'b1, 1'b0, 28'h20, 8'h00);
    nxt();
    for (int c = 1; c <= TO; c++) begin
      #1;
      total_cnt++;
      if ({cyc, grant, m_stall[2], timeout} !== {1'b1, 4'b0010, 1'b1, 1'b0})
        $display("FAIL to_wait c=%0d got cyc=%b grant=%b stall2=%b to=%b exp 1 0010 1 0",
                 c, cyc, grant, m_stall[2], timeout);
      else pass_cnt++;
      nxt();
    end
    exp_q.push_back({4'b0000, 4'b0010});
    #1;
    total_cnt++;
    if ({timeout, cyc, m_err} !== {1'b1, 1'b0, 4'b0010})
      $display("FAIL to_abort got to=%b cyc=%b err=%b exp 1 0 0010", timeout, cyc, m_err);
    else pass_cnt++;
    nxt();
    #1;
    total_cnt++;
    if ({cyc, grant, timeout} !== 6'b0_0000_0) $display("FAIL to_idle got=%b exp=000000", {cyc, grant, timeout}); else pass_cnt++;
    nxt();
    total_cnt++;
    if ({cyc, grant, adr} !== {1'b1, 4'b0100, 28'h20}) $display("FAIL to_next got cyc=%b grant=%b adr=%h exp 1 0100 20", cyc, grant, adr); else pass_cnt++;
    s_ack = 1'b1;
    exp_q.push_back({4'b0100, 4'b0000});
    nxt();
    s_ack = 1'b0;
    drive_m(2, 1'b0, 1'b0, 1'b0, '0, '0);
    nxt();
    #1;
    total_cnt++;
    if (grant !== 4'b0000) $display("FAIL to_lockout got=%b exp=0000", grant); else pass_cnt++;
    drive_m(1, 1'b0, 1'b0, 1'b0, 28'h10, 8'h11);
    nxt();
    drive_m(1, 1'b1, 1'b1, 1'b1, 28'h10, 8'h11);
    nxt();
    #1;
    total_cnt++;
    if ({cyc, grant} !== {1'b1, 4'b0010}) $display("FAIL to_rejoin got=%b exp=10010", {cyc, grant}); else pass_cnt++;
    m_cyc = '0; m_stb = '0;
    nxt();
    nxt();
  endtask

  task automatic test_ack_at_limit();
    do_reset();
    drive_m(0, 1'b1, 1'b1, 1'b0, 28'h30, 8'h00);
    nxt();
    for (int c = 1; c < TO; c++) nxt();
    s_ack = 1'b1;
    exp_q.push_back({4'b0001, 4'b0000});
    #1;
    total_cnt++;
    if (m_ack !== 4'b0001) $display("FAIL lim_ack got=%b exp=0001", m_ack); else pass_cnt++;
    nxt();
    s_ack = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      #1;
      total_cnt++;
      if ({cyc, timeout} !== 2'b10) $display("FAIL lim_noabort c=%0d got=%b exp=10", c, {cyc, timeout}); else pass_cnt++;
      nxt();
    end
    exp_q.push_back({4'b0000, 4'b0001});
    #1;
    total_cnt++;
    if ({timeout, m_err} !== 5'b1_0001) $display("FAIL lim_recount got=%b exp=10001", {timeout, m_err}); else pass_cnt++;
    m_cyc = '0; m_stb = '0;
    nxt();
    nxt();
  endtask

  task automatic test_stall();
    do_reset();
    drive_m(2, 1'b1, 1'b1, 1'b1, 28'h40, 8'h5A);
    nxt();
    drive_m(0, 1'b1, 1'b1, 1'b0, 28'h50, 8'h00);
    for (int c = 0; c < 5; c++) begin
      s_stall = (c < 4);
      #1;
      total_cnt++;
      if ({grant, m_stall[0], m_stall[2]} !== {4'b0100, 1'b1, s_stall})
        $display("FAIL stall c=%0d got grant=%b st0=%b st2=%b exp 0100 1 %b",
                 c, grant, m_stall[0], m_stall[2], s_stall);
      else pass_cnt++;
      if (c == 4) begin
        s_ack = 1'b1;
        exp_q.push_back({4'b0100, 4'b0000});
      end
      nxt();
    end
    s_ack = 1'b0;
    s_stall = 1'b0;
    drive_m(2, 1'b0, 1'b0, 1'b0, '0, '0);
    nxt();
    #1;
    total_cnt++;
    if ({cyc, grant, adr} !== {1'b1, 4'b0001, 28'h50}) $display("FAIL stall_handover got cyc=%b grant=%b adr=%h exp 1 0001 50", cyc, grant, adr); else pass_cnt++;
    s_ack = 1'b1;
    exp_q.push_back({4'b0001, 4'b0000});
    nxt();
    s_ack = 1'b0;
    m_cyc = '0; m_stb = '0;
    nxt();
    nxt();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_m(3, 1'b1, 1'b1, 1'b0, 28'h60, 8'h00);
    nxt();
    #1;
    total_cnt++;
    if (grant !== 4'b1000) $display("FAIL rm_grant got=%b exp=1000", grant); else pass_cnt++;
    nxt();
    nxt();
    rst = 1'b1;
    drive_m(0, 1'b1, 1'b1, 1'b0, 28'h70, 8'h00);
    nxt();
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({cyc, grant, m_ack, m_err} !== 13'b0) $display("FAIL rm_drop got=%b exp=0", {cyc, grant, m_ack, m_err}); else pass_cnt++;
    nxt();
    total_cnt++;
    if ({cyc, grant, adr} !== {1'b1, 4'b0001, 28'h70}) $display("FAIL rm_prio got cyc=%b grant=%b adr=%h exp 1 0001 70", cyc, grant, adr); else pass_cnt++;
    s_ack = 1'b1;
    exp_q.push_back({4'b0001, 4'b0000});
    nxt();
    s_ack = 1'b0;
    m_cyc = '0; m_stb = '0;
    nxt();
    nxt();
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_round_robin();
    test_timeout();
    test_ack_at_limit();
    test_stall();
    test_reset_mid();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
